// File: rtl/uart_tx_framer_if.sv
// Byte-stream handshake feeding the UART transmit framer.
interface uart_tx_framer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: FIFO-buffered bytes serialised as start/data/stop on tx, timed by baud_clk toggles.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN (sense selected by PARITY_ODD).
module uart_tx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_framer_if.slave   stream,
  input  logic              baud_clk,
  output logic              baud_en,
  output logic              tx,
  output logic              busy
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
  localparam logic [1:0]    LAST_STOP  = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [DATA_BITS-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]        count_r, count_s;
  logic                 s_ready_r;
  logic                 baud_d_r;
  logic                 tick_s, push_s, pop_s, fifo_empty_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [BW-1:0]        bit_cnt_r, bit_cnt_s;
  logic [1:0]           stop_cnt_r, stop_cnt_s;
  logic                 tx_r, tx_s, baud_en_r, baud_en_s, busy_r, busy_s;

`ifdef UART_TX_PARITY_EN
  logic parity_r, parity_s;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction
`else
  localparam bit unused_parity_odd = (PARITY_ODD != 0);
`endif

  assign push_s        = stream.s_valid && s_ready_r;
  assign fifo_empty_s  = (count_r == CW'(0));
  assign tick_s        = (baud_clk ^ baud_d_r) & baud_en_r;
  assign stream.s_ready = s_ready_r;
  assign tx            = tx_r;
  assign baud_en       = baud_en_r;
  assign busy          = busy_r;

  // Edge-detect register for baud_clk; follows the line even during reset
  always_ff @(posedge clk) begin
    baud_d_r <= baud_clk;
  end

  // FIFO payload storage, written only at push
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= stream.s_data;
    end
  end

  // FIFO occupancy after this cycle's push and pop
  always_comb begin
    count_s = count_r;
    if (push_s && !pop_s) begin
      count_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_s = count_r - CW'(1);
    end else begin
      count_s = count_r;
    end
  end

  // FIFO pointers, count and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      s_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r   <= count_s;
      s_ready_r <= (count_s != FULL_COUNT);
    end
  end

  // Frame sequencer: next state, shift/counter updates and next line levels
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_cnt_s  = bit_cnt_r;
    stop_cnt_s = stop_cnt_r;
    tx_s       = tx_r;
    baud_en_s  = baud_en_r;
    busy_s     = busy_r;
    pop_s      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_s   = parity_r;
`endif
    case (state_r)
      IDLE: begin
        tx_s      = 1'b1;
        baud_en_s = 1'b0;
        busy_s    = 1'b0;
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          shift_s   = fifo_mem_r[rd_ptr_r];
`ifdef UART_TX_PARITY_EN
          parity_s  = parity_of(fifo_mem_r[rd_ptr_r]);
`endif
          state_s   = START;
          tx_s      = 1'b0;
          baud_en_s = 1'b1;
          busy_s    = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_s   = DATA;
          tx_s      = shift_r[0];
          bit_cnt_s = '0;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shift_s   = {1'b0, shift_r[DATA_BITS-1:1]};
          bit_cnt_s = bit_cnt_r + BW'(1);
          if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_s    = PARITY;
            tx_s       = parity_r;
`else
            state_s    = STOP;
            tx_s       = 1'b1;
            stop_cnt_s = 2'd0;
`endif
          end else begin
            tx_s = shift_r[1];
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_s) begin
          state_s    = STOP;
          tx_s       = 1'b1;
          stop_cnt_s = 2'd0;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick_s) begin
          stop_cnt_s = stop_cnt_r + 2'd1;
          if (stop_cnt_r == LAST_STOP) begin
            // Chain straight into the next frame so back-to-back bytes have no idle gap
            if (!fifo_empty_s) begin
              pop_s    = 1'b1;
              shift_s  = fifo_mem_r[rd_ptr_r];
`ifdef UART_TX_PARITY_EN
              parity_s = parity_of(fifo_mem_r[rd_ptr_r]);
`endif
              state_s  = START;
              tx_s     = 1'b0;
            end else begin
              state_s   = IDLE;
              tx_s      = 1'b1;
              baud_en_s = 1'b0;
              busy_s    = 1'b0;
            end
          end else begin
            state_s = STOP;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        tx_s      = 1'b1;
        baud_en_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      stop_cnt_r <= 2'd0;
      tx_r       <= 1'b1;
      baud_en_r  <= 1'b0;
      busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_cnt_r  <= bit_cnt_s;
      stop_cnt_r <= stop_cnt_s;
      tx_r       <= tx_s;
      baud_en_r  <= baud_en_s;
      busy_r     <= busy_s;
`ifdef UART_TX_PARITY_EN
      parity_r   <= parity_s;
`endif
    end
  end
endmodule
